// File: rtl/uart_rx.sv
// UART receiver: 8N1 framing, LSB first, oversampled by an external baud tick.
// The line is resynchronised, the start bit is confirmed at mid-bit, and each
// data and stop bit is sampled at the centre of its bit period. A received
// byte is held in an output register until the consumer accepts it.
module uart_rx #(
  parameter int DataBits       = 8,
  parameter int OverSampleRate = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                baudx16_tick_i,
  input  logic                rx_i,
  input  logic                rx_ready_i,
  output logic [DataBits-1:0] rx_data_o,
  output logic                rx_valid_o,
  output logic                rx_busy_o,
  output logic                frame_err_o,
  output logic                overrun_o
);

  localparam int TickW = $clog2(OverSampleRate);
  localparam int BitW  = $clog2(DataBits + 1);

  localparam logic [TickW-1:0] HalfTick = TickW'(OverSampleRate / 2 - 1);
  localparam logic [TickW-1:0] LastTick = TickW'(OverSampleRate - 1);
  localparam logic [BitW-1:0]  LastBit  = BitW'(DataBits - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    RECOVER
  } state_e;

  logic                rxMeta_q;
  logic                rxSync_q;
  state_e              state_q, state_d;
  logic [TickW-1:0]    tickCnt_q, tickCnt_d;
  logic [BitW-1:0]     bitCnt_q, bitCnt_d;
  logic [DataBits-1:0] shift_q, shift_d;
  logic [DataBits-1:0] rxData_q, rxData_d;
  logic                rxValid_q, rxValid_d;
  logic                frameErr_q, frameErr_d;
  logic                overrun_q, overrun_d;
  logic                loadByte;
  logic                stopErr;

  // Two-flop synchronizer; resets to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
    end else begin
      rxMeta_q <= rx_i;
      rxSync_q <= rxMeta_q;
    end
  end

  // Frame state, oversample counter, bit counter and shift register; all advance only on baud ticks.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      tickCnt_q <= '0;
      bitCnt_q  <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      tickCnt_q <= tickCnt_d;
      bitCnt_q  <= bitCnt_d;
      shift_q   <= shift_d;
    end
  end

  // Next-state logic: start detect, mid-bit start confirm, centre sampling of data and stop bits, break recovery.
  always_comb begin
    state_d   = state_q;
    tickCnt_d = tickCnt_q;
    bitCnt_d  = bitCnt_q;
    shift_d   = shift_q;
    loadByte  = 1'b0;
    stopErr   = 1'b0;
    if (baudx16_tick_i) begin
      case (state_q)
        IDLE: begin
          if (!rxSync_q) begin
            state_d   = START;
            tickCnt_d = '0;
          end
        end
        START: begin
          if (tickCnt_q == HalfTick) begin
            tickCnt_d = '0;
            if (!rxSync_q) begin
              state_d  = DATA;
              bitCnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tickCnt_d = tickCnt_q + TickW'(1);
          end
        end
        DATA: begin
          if (tickCnt_q == LastTick) begin
            shift_d               = shift_q >> 1;
            shift_d[DataBits-1]   = rxSync_q;
            tickCnt_d             = '0;
            bitCnt_d              = bitCnt_q + BitW'(1);
            if (bitCnt_q == LastBit) begin
              state_d = STOP;
            end
          end else begin
            tickCnt_d = tickCnt_q + TickW'(1);
          end
        end
        STOP: begin
          if (tickCnt_q == LastTick) begin
            tickCnt_d = '0;
            if (rxSync_q) begin
              loadByte = 1'b1;
              state_d  = IDLE;
            end else begin
              stopErr = 1'b1;
              state_d = RECOVER;
            end
          end else begin
            tickCnt_d = tickCnt_q + TickW'(1);
          end
        end
        RECOVER: begin
          if (rxSync_q) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d   = IDLE;
          tickCnt_d = '0;
          bitCnt_d  = '0;
        end
      endcase
    end
  end

  // Output holding register: a new byte always wins; an unconsumed byte being replaced flags an overrun.
  always_comb begin
    rxData_d   = rxData_q;
    rxValid_d  = rxValid_q;
    frameErr_d = stopErr;
    overrun_d  = 1'b0;
    if (loadByte) begin
      rxData_d  = shift_q;
      rxValid_d = 1'b1;
      overrun_d = rxValid_q & ~rx_ready_i;
    end else if (rx_ready_i) begin
      rxValid_d = 1'b0;
    end
  end

  // Registered outputs so valid, data and the error pulses are glitch-free to the consumer.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rxData_q   <= '0;
      rxValid_q  <= 1'b0;
      frameErr_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      rxData_q   <= rxData_d;
      rxValid_q  <= rxValid_d;
      frameErr_q <= frameErr_d;
      overrun_q  <= overrun_d;
    end
  end

  assign rx_data_o   = rxData_q;
  assign rx_valid_o  = rxValid_q;
  assign rx_busy_o   = (state_q != IDLE);
  assign frame_err_o = frameErr_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: baud tick every 4 clocks, 16 ticks per bit,
// so one serial bit lasts 64 clocks. Frames start aligned to a tick so the
// stop-bit sampling cycle is known exactly (612 negedges after the start edge).
module tb_uart_rx;

  logic       clk;
  logic       rst_ni;
  logic       baudTick;
  logic       rx_i;
  logic       rx_ready_i;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_busy_o;
  logic       frame_err_o;
  logic       overrun_o;

  int checks = 0;
  int errors = 0;

  int tickPhase = 0;
  int frameErrCnt = 0;
  int overrunCnt = 0;
  int busyHighCnt = 0;
  int validRiseCnt = 0;
  logic prevValid = 1'b0;

  uart_rx #(
    .DataBits(8),
    .OverSampleRate(16)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .baudx16_tick_i(baudTick),
    .rx_i(rx_i),
    .rx_ready_i(rx_ready_i),
    .rx_data_o(rx_data_o),
    .rx_valid_o(rx_valid_o),
    .rx_busy_o(rx_busy_o),
    .frame_err_o(frame_err_o),
    .overrun_o(overrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Baud strobe: high for exactly one rising edge out of every four.
  always @(negedge clk) begin
    tickPhase = (tickPhase + 1) % 4;
    baudTick  = (tickPhase == 0);
  end

  // Running tallies of output events, sampled on the falling edge.
  always @(negedge clk) begin
    if (frame_err_o === 1'b1) frameErrCnt++;
    if (overrun_o === 1'b1) overrunCnt++;
    if (rx_busy_o === 1'b1) busyHighCnt++;
    if (rx_valid_o === 1'b1 && !prevValid) validRiseCnt++;
    prevValid = (rx_valid_o === 1'b1);
  end

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Drives one 8N1 frame for numCycles clocks, optionally pulsing ready at one cycle, and counts busy gaps mid-frame.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input int numCycles,
                               input int readyCycle, output int busyGaps);
    int bitIdx;
    busyGaps = 0;
    do begin
      @(negedge clk);
      #1;
    end while (tickPhase != 0);
    for (int c = 0; c < numCycles; c++) begin
      bitIdx = c / 64;
      if (bitIdx == 0) rx_i = 1'b0;
      else if (bitIdx <= 8) rx_i = data[bitIdx-1];
      else rx_i = stopBit;
      rx_ready_i = (c == readyCycle);
      if (c >= 16 && c <= 600 && rx_busy_o !== 1'b1) busyGaps++;
      @(negedge clk);
      #1;
    end
    rx_ready_i = 1'b0;
  endtask

  task automatic consume();
    rx_ready_i = 1'b1;
    waitCycles(1);
    rx_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    rx_i = 1'b1;
    rx_ready_i = 1'b0;
    waitCycles(6);
    checks++;
    if (rx_data_o !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_data: got %h expected 00", rx_data_o);
    end
    checks++;
    if (rx_valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_valid: got %b expected 0", rx_valid_o);
    end
    checks++;
    if (rx_busy_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_busy: got %b expected 0", rx_busy_o);
    end
    checks++;
    if ({frame_err_o, overrun_o} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_pulses: got %b expected 00", {frame_err_o, overrun_o});
    end
    rst_ni = 1'b1;
    waitCycles(20);
  endtask

  task automatic test_basic();
    int gaps;
    int fe0 = frameErrCnt;
    int ov0 = overrunCnt;
    applyStimulus(8'hA5, 1'b1, 640, -1, gaps);
    checks++;
    if (rx_data_o !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL basic_data: got %h expected a5", rx_data_o);
    end
    checks++;
    if (rx_valid_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_valid: got %b expected 1", rx_valid_o);
    end
    checks++;
    if (gaps !== 0) begin
      errors++;
      $display("[TB] FAIL basic_busy_in_frame: got %0d idle cycles expected 0", gaps);
    end
    checks++;
    if (rx_busy_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_busy_after: got %b expected 0", rx_busy_o);
    end
    waitCycles(200);
    checks++;
    if (rx_valid_o !== 1'b1 || rx_data_o !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL basic_hold: got valid=%b data=%h expected valid=1 data=a5", rx_valid_o, rx_data_o);
    end
    checks++;
    if (frameErrCnt - fe0 !== 0 || overrunCnt - ov0 !== 0) begin
      errors++;
      $display("[TB] FAIL basic_no_errors: got fe=%0d ov=%0d expected 0 0", frameErrCnt - fe0, overrunCnt - ov0);
    end
  endtask

  task automatic test_consume();
    int ov0 = overrunCnt;
    consume();
    checks++;
    if (rx_valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL consume_clear: got %b expected 0", rx_valid_o);
    end
    consume();
    waitCycles(3);
    checks++;
    if (rx_valid_o !== 1'b0 || overrunCnt - ov0 !== 0) begin
      errors++;
      $display("[TB] FAIL consume_idle_ready: got valid=%b ov=%0d expected 0 0", rx_valid_o, overrunCnt - ov0);
    end
  endtask

  task automatic test_patterns();
    logic [7:0] pats [4] = '{8'h00, 8'h80, 8'h01, 8'hFF};
    int gaps;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(pats[i], 1'b1, 640, -1, gaps);
      checks++;
      if (rx_data_o !== pats[i] || rx_valid_o !== 1'b1) begin
        errors++;
        $display("[TB] FAIL pattern_%0d: got data=%h valid=%b expected data=%h valid=1", i, rx_data_o, rx_valid_o, pats[i]);
      end
      consume();
      waitCycles(20);
    end
  endtask

  task automatic test_glitch();
    int gaps;
    int bh0 = busyHighCnt;
    int vr0 = validRiseCnt;
    applyStimulus(8'h00, 1'b1, 20, -1, gaps);
    rx_i = 1'b1;
    waitCycles(60);
    checks++;
    if (busyHighCnt - bh0 <= 0) begin
      errors++;
      $display("[TB] FAIL glitch_detected: got %0d busy cycles expected >0", busyHighCnt - bh0);
    end
    checks++;
    if (rx_busy_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL glitch_busy_after: got %b expected 0", rx_busy_o);
    end
    checks++;
    if (rx_valid_o !== 1'b0 || validRiseCnt - vr0 !== 0) begin
      errors++;
      $display("[TB] FAIL glitch_no_valid: got valid=%b rises=%0d expected 0 0", rx_valid_o, validRiseCnt - vr0);
    end
  endtask

  task automatic test_frame_error();
    int gaps;
    int fe0 = frameErrCnt;
    int vr0 = validRiseCnt;
    applyStimulus(8'h3C, 1'b0, 640, -1, gaps);
    waitCycles(160);
    checks++;
    if (frameErrCnt - fe0 !== 1) begin
      errors++;
      $display("[TB] FAIL ferr_pulse: got %0d cycles expected 1", frameErrCnt - fe0);
    end
    checks++;
    if (rx_valid_o !== 1'b0 || validRiseCnt - vr0 !== 0) begin
      errors++;
      $display("[TB] FAIL ferr_no_valid: got valid=%b rises=%0d expected 0 0", rx_valid_o, validRiseCnt - vr0);
    end
    checks++;
    if (rx_busy_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ferr_recover_busy: got %b expected 1", rx_busy_o);
    end
    rx_i = 1'b1;
    waitCycles(20);
    checks++;
    if (rx_busy_o !== 1'b0 || frameErrCnt - fe0 !== 1) begin
      errors++;
      $display("[TB] FAIL ferr_recover_exit: got busy=%b fe=%0d expected 0 1", rx_busy_o, frameErrCnt - fe0);
    end
  endtask

  task automatic test_overrun();
    int gaps;
    int ov0 = overrunCnt;
    applyStimulus(8'h11, 1'b1, 640, -1, gaps);
    checks++;
    if (rx_data_o !== 8'h11 || rx_valid_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overrun_first: got data=%h valid=%b expected 11 1", rx_data_o, rx_valid_o);
    end
    waitCycles(20);
    applyStimulus(8'h22, 1'b1, 640, -1, gaps);
    checks++;
    if (overrunCnt - ov0 !== 1) begin
      errors++;
      $display("[TB] FAIL overrun_pulse: got %0d cycles expected 1", overrunCnt - ov0);
    end
    checks++;
    if (rx_data_o !== 8'h22 || rx_valid_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overrun_data: got data=%h valid=%b expected 22 1", rx_data_o, rx_valid_o);
    end
  endtask

  task automatic test_back_to_back();
    int gaps;
    int ov0;
    consume();
    waitCycles(10);
    ov0 = overrunCnt;
    applyStimulus(8'h11, 1'b1, 640, -1, gaps);
    waitCycles(20);
    applyStimulus(8'h22, 1'b1, 640, 612, gaps);
    checks++;
    if (overrunCnt - ov0 !== 0) begin
      errors++;
      $display("[TB] FAIL b2b_no_overrun: got %0d cycles expected 0", overrunCnt - ov0);
    end
    checks++;
    if (rx_data_o !== 8'h22 || rx_valid_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_data: got data=%h valid=%b expected 22 1", rx_data_o, rx_valid_o);
    end
  endtask

  task automatic test_reset_midframe();
    int gaps;
    int nonZero = 0;
    int fe0 = frameErrCnt;
    int ov0 = overrunCnt;
    int vr0;
    applyStimulus(8'hFF, 1'b1, 340, -1, gaps);
    rst_ni = 1'b0;
    waitCycles(1);
    for (int i = 0; i < 8; i++) begin
      if ({rx_data_o, rx_valid_o, rx_busy_o, frame_err_o, overrun_o} !== 12'h000) nonZero++;
      waitCycles(1);
    end
    checks++;
    if (nonZero !== 0) begin
      errors++;
      $display("[TB] FAIL rstmid_outputs_zero: got %0d nonzero cycles expected 0", nonZero);
    end
    rst_ni = 1'b1;
    waitCycles(100);
    vr0 = validRiseCnt;
    applyStimulus(8'h81, 1'b1, 640, -1, gaps);
    waitCycles(20);
    checks++;
    if (rx_data_o !== 8'h81 || rx_valid_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rstmid_data: got data=%h valid=%b expected 81 1", rx_data_o, rx_valid_o);
    end
    checks++;
    if (validRiseCnt - vr0 !== 1 || frameErrCnt - fe0 !== 0 || overrunCnt - ov0 !== 0) begin
      errors++;
      $display("[TB] FAIL rstmid_single_delivery: got rises=%0d fe=%0d ov=%0d expected 1 0 0",
               validRiseCnt - vr0, frameErrCnt - fe0, overrunCnt - ov0);
    end
  endtask

  initial begin
    baudTick = 1'b0;
    rst_ni = 1'b0;
    rx_i = 1'b1;
    rx_ready_i = 1'b0;
    test_reset();
    test_basic();
    test_consume();
    test_patterns();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DataBits, default 8: data bits per frame (8N1 framing, LSB first).
REQ-002 SHALL have parameter OverSampleRate, default 16: baudx16 ticks per bit period.
REQ-003 SHALL have port clk_i, input, 1: single clock; all logic on posedge.
REQ-004 SHALL have port rst_ni, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port baudx16_tick_i, input, 1: one-cycle oversample strobe from the baud generator.
REQ-006 SHALL have port rx_i, input, 1: asynchronous serial line, idle high.
REQ-007 SHALL have port rx_ready_i, input, 1: consumer accepts rx_data_o this cycle.
REQ-008 SHALL have port rx_data_o, output, DataBits: received byte, stable while rx_valid_o=1.
REQ-009 SHALL have port rx_valid_o, output, 1: rx_data_o holds an unconsumed byte.
REQ-010 SHALL have port rx_busy_o, output, 1: frame in progress; drives the baud generator rx_busy_i.
REQ-011 SHALL have port frame_err_o, output, 1: one-cycle pulse, stop bit sampled low.
REQ-012 SHALL have port overrun_o, output, 1: one-cycle pulse, unconsumed byte overwritten.

Function
REQ-013 SHALL pass rx_i through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-014 SHALL advance the FSM and the tick/bit counters only on cycles with baudx16_tick_i=1; with no tick, the FSM and counters hold.
REQ-015 SHALL implement states IDLE, START, DATA, STOP, RECOVER.
REQ-016 IDLE: on a tick with synchronized rx=0 -> START, tick_cnt=0.
REQ-017 START: on the tick where tick_cnt==OverSampleRate/2-1, rx=0 -> DATA with tick_cnt=0, bit_cnt=0; rx=1 -> IDLE (glitch rejected, no output).
REQ-018 DATA: on the tick where tick_cnt==OverSampleRate-1, sample rx into the shift register LSB first, clear tick_cnt, increment bit_cnt; after DataBits samples -> STOP.
REQ-019 STOP: on the tick where tick_cnt==OverSampleRate-1, rx=1 -> load rx_data_o, set rx_valid_o, go IDLE; rx=0 -> pulse frame_err_o, discard byte, go RECOVER.
REQ-020 RECOVER: remain until a tick samples rx=1, then go IDLE (a break condition SHALL NOT retrigger frames).
REQ-021 Counter widths SHALL be $clog2(OverSampleRate) and $clog2(DataBits+1); no wrap occurs within a frame.
REQ-022 rx_busy_o SHALL be 1 in START, DATA, STOP, RECOVER and 0 in IDLE.
REQ-023 rx_valid_o SHALL rise the cycle after the stop-bit-sampling tick and stay high until a cycle with rx_ready_i=1, after which it clears.
REQ-024 When a new byte loads while rx_valid_o=1 and rx_ready_i=0: overwrite rx_data_o, keep rx_valid_o=1, pulse overrun_o.
REQ-025 When a new byte loads in the same cycle as rx_ready_i=1: the new byte loads, rx_valid_o stays 1, no overrun.
REQ-026 rx_ready_i with rx_valid_o=0 SHALL have no effect.

Reset
REQ-027 With rst_ni=0 at a clock edge: state IDLE, counters 0, shift register 0, synchronizer flops 1, rx_data_o=0, rx_valid_o=0, rx_busy_o=0, frame_err_o=0, overrun_o=0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame with no rx_valid_o, frame_err_o, or overrun_o.

Verification
REQ-029 Tick every 4 clocks; send 0xA5 8N1 at 16 ticks/bit, rx_ready_i=0 -> rx_data_o=0xA5, rx_valid_o=1 and held; rx_busy_o=1 from start detect through the stop sample.
REQ-030 rx_i low for 5 ticks, then high -> START aborts to IDLE; rx_valid_o=0, rx_busy_o returns to 0.
REQ-031 Send 0x3C with the stop bit held low, then the line stays low for 40 ticks -> frame_err_o one pulse; no rx_valid_o; FSM in RECOVER until the line returns high.
REQ-032 Send 0x11 then 0x22 with rx_ready_i=0 -> overrun_o one pulse; rx_data_o=0x22; rx_valid_o=1.
REQ-033 Send 0x11, then assert rx_ready_i on exactly the cycle 0x22 loads -> no overrun; rx_data_o=0x22; rx_valid_o=1.
REQ-034 Assert rst_ni=0 during data bit 4 of 0xFF, then release and send 0x81 -> only 0x81 is delivered; all outputs are 0 during reset.
